// File: rtl/interleave_example_axi_slave_mem.sv
// interleave_example_axi_slave_mem
// AXI4 responder (INCR bursts only) backed by an on-chip word array.
// Independent write (AW/W/B) and read (AR/R) state machines share one
// dual-port array: one byte-enabled write port, one registered read port.
module interleave_example_axi_slave_mem #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH_WORDS  = 1024
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  // write address channel
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                        s_axi_awlen,
  // write data channel
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wlast,
  // write response channel (always OKAY)
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  // read address channel
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                        s_axi_arlen,
  // read data channel
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic                              s_axi_rlast,
  // sticky protocol error: wlast disagreed with the awlen beat count
  output logic                              wlast_err
);

  localparam int LP_DW_BYTES = C_M_AXI_DATA_WIDTH / 8;
  localparam int LP_OFF_W    = $clog2(LP_DW_BYTES);
  localparam int LP_IDX_W    = $clog2(C_MEM_DEPTH_WORDS);
  // beat counters hold up to 256 (awlen/arlen + 1)
  localparam int LP_CNT_W    = 9;

  // INIT is the state reset lands in, so every ready stays low for the
  // cycle in which reset release is being sampled.
  typedef enum logic [1:0] {
    WR_INIT = 2'd0,
    WR_IDLE = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_INIT  = 2'd0,
    RD_IDLE  = 2'd1,
    RD_BURST = 2'd2
  } rd_state_e;

  // storage; deliberately not cleared by reset
  logic [C_M_AXI_DATA_WIDTH-1:0] mem_q [C_MEM_DEPTH_WORDS];

  // write side
  wr_state_e             wr_state_q, wr_state_d;
  logic [LP_IDX_W-1:0]   wr_idx_q,   wr_idx_d;
  logic [LP_CNT_W-1:0]   wr_left_q,  wr_left_d;
  logic                  wlast_err_q, wlast_err_d;
  logic                  wr_is_last;
  logic                  wr_fire;

  // read side
  rd_state_e             rd_state_q, rd_state_d;
  logic [LP_IDX_W-1:0]   rd_idx_q,   rd_idx_d;
  logic [LP_CNT_W-1:0]   rd_left_q,  rd_left_d;
  logic                  rvalid_q,   rvalid_d;
  logic                  rlast_q,    rlast_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q;
  logic                  rd_issue;
  logic                  r_hs;

  // Address bits outside the word index are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr[C_M_AXI_ADDR_WIDTH-1:LP_OFF_W+LP_IDX_W],
                              s_axi_awaddr[LP_OFF_W-1:0],
                              s_axi_araddr[C_M_AXI_ADDR_WIDTH-1:LP_OFF_W+LP_IDX_W],
                              s_axi_araddr[LP_OFF_W-1:0]};

  // ---------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------
  assign wr_is_last = (wr_left_q == LP_CNT_W'(1));
  // A beat is only committed when reset is not being sampled on that edge.
  assign wr_fire    = aresetn && (wr_state_q == WR_DATA) && s_axi_wvalid;

  // Write FSM next state: beat count, not wlast, terminates the burst.
  always_comb begin
    wr_state_d  = wr_state_q;
    wr_idx_d    = wr_idx_q;
    wr_left_d   = wr_left_q;
    wlast_err_d = wlast_err_q;
    case (wr_state_q)
      WR_INIT: begin
        wr_state_d = WR_IDLE;
      end
      WR_IDLE: begin
        if (s_axi_awvalid) begin
          wr_state_d = WR_DATA;
          wr_idx_d   = s_axi_awaddr[LP_OFF_W +: LP_IDX_W];
          wr_left_d  = LP_CNT_W'(s_axi_awlen) + LP_CNT_W'(1);
        end
      end
      WR_DATA: begin
        if (s_axi_wvalid) begin
          // index wraps naturally modulo the power-of-two depth
          wr_idx_d  = wr_idx_q + LP_IDX_W'(1);
          wr_left_d = wr_left_q - LP_CNT_W'(1);
          if (s_axi_wlast != wr_is_last) begin
            wlast_err_d = 1'b1;
          end
          if (wr_is_last) begin
            wr_state_d = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        if (s_axi_bready) begin
          wr_state_d = WR_IDLE;
        end
      end
      default: begin
        wr_state_d = WR_INIT;
      end
    endcase
  end

  // Write FSM registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_state_q  <= WR_INIT;
      wr_idx_q    <= '0;
      wr_left_q   <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      wr_idx_q    <= wr_idx_d;
      wr_left_q   <= wr_left_d;
      wlast_err_q <= wlast_err_d;
    end
  end

  // Byte-enabled write port of the array.
  always_ff @(posedge aclk) begin
    if (wr_fire) begin
      for (int b = 0; b < LP_DW_BYTES; b++) begin
        if (s_axi_wstrb[b]) begin
          mem_q[wr_idx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign s_axi_awready = (wr_state_q == WR_IDLE);
  assign s_axi_wready  = (wr_state_q == WR_DATA);
  assign s_axi_bvalid  = (wr_state_q == WR_RESP);
  assign wlast_err     = wlast_err_q;

  // ---------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------
  assign r_hs     = rvalid_q && s_axi_rready;
  // Refill the output register whenever it is empty or drained this cycle,
  // so a continuously ready master sees one beat per cycle.
  assign rd_issue = (rd_state_q == RD_BURST) && (rd_left_q != '0) &&
                    (!rvalid_q || s_axi_rready);

  // Read FSM next state plus the R output register control.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_idx_d   = rd_idx_q;
    rd_left_d  = rd_left_q;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    case (rd_state_q)
      RD_INIT: begin
        rd_state_d = RD_IDLE;
      end
      RD_IDLE: begin
        if (s_axi_arvalid) begin
          rd_state_d = RD_BURST;
          rd_idx_d   = s_axi_araddr[LP_OFF_W +: LP_IDX_W];
          rd_left_d  = LP_CNT_W'(s_axi_arlen) + LP_CNT_W'(1);
        end
      end
      RD_BURST: begin
        if (rd_issue) begin
          rd_idx_d  = rd_idx_q + LP_IDX_W'(1);
          rd_left_d = rd_left_q - LP_CNT_W'(1);
          rvalid_d  = 1'b1;
          rlast_d   = (rd_left_q == LP_CNT_W'(1));
        end else if (r_hs) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
        end
        // the final beat leaves the register empty (nothing left to issue)
        if (r_hs && rlast_q) begin
          rd_state_d = RD_IDLE;
        end
      end
      default: begin
        rd_state_d = RD_INIT;
      end
    endcase
  end

  // Read FSM and R-channel control registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_state_q <= RD_INIT;
      rd_idx_q   <= '0;
      rd_left_q  <= '0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_idx_q   <= rd_idx_d;
      rd_left_q  <= rd_left_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
    end
  end

  // Registered read port; a same-edge write to the same word is not seen.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rdata_q <= '0;
    end else if (rd_issue) begin
      rdata_q <= mem_q[rd_idx_q];
    end
  end

  assign s_axi_arready = (rd_state_q == RD_IDLE);
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_interleave_example_axi_slave_mem.sv
// tb_interleave_example_axi_slave_mem
// Randomized AXI bursts against a behavioural word-array model; one negedge
// monitor compares every meaningful DUT output, the main thread adds a few
// hand-computed literal expectations.
module tb_interleave_example_axi_slave_mem;

  localparam int AW    = 64;
  localparam int DW    = 512;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [DW-1:0] wdata = '0;
  logic [NB-1:0] wstrb = '0;
  logic          wlast = 1'b0;
  logic          bvalid;
  logic          bready = 1'b0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [AW-1:0] araddr = '0;
  logic [7:0]    arlen = '0;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [DW-1:0] rdata;
  logic          rlast;
  logic          wlast_err;

  always #5 clk = ~clk;

  interleave_example_axi_slave_mem #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .C_MEM_DEPTH_WORDS (DEPTH)
  ) dut (
    .aclk         (clk),
    .aresetn      (aresetn),
    .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_awaddr (awaddr),
    .s_axi_awlen  (awlen),
    .s_axi_wvalid (wvalid),
    .s_axi_wready (wready),
    .s_axi_wdata  (wdata),
    .s_axi_wstrb  (wstrb),
    .s_axi_wlast  (wlast),
    .s_axi_bvalid (bvalid),
    .s_axi_bready (bready),
    .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_araddr (araddr),
    .s_axi_arlen  (arlen),
    .s_axi_rvalid (rvalid),
    .s_axi_rready (rready),
    .s_axi_rdata  (rdata),
    .s_axi_rlast  (rlast),
    .wlast_err    (wlast_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [DW-1:0] d;
    bit            known;
    bit            last;
  } beat_t;

  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  beat_t         exp_q[$];
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] wd_q[$];
  logic [NB-1:0] ws_q[$];

  bit  wr_busy = 0, rd_busy = 0, m_err = 0, prev_rst = 1;
  bit  prev_stall = 0, prev_hs = 0;
  int  wr_idx = 0, wr_left = 0, rd_lat = 0;
  logic [DW-1:0] prev_rdata;
  logic          prev_rlast;

  // Compare on every falling edge, then fold the handshakes that the coming
  // rising edge will perform into the model.
  initial begin
    beat_t e;
    bit    lastpop;
    int    idx;
    forever begin
      @(negedge clk);
      lastpop = 0;
      if (prev_rst) begin
        chk("reset_outputs", {awready, wready, bvalid, arready, rvalid, rlast, wlast_err, |rdata}, '0);
      end else begin
        chk("awready", awready, !wr_busy);
        chk("wready", wready, wr_busy && wr_left > 0);
        chk("bvalid", bvalid, wr_busy && wr_left == 0);
        chk("arready", arready, !rd_busy);
        chk("wlast_err", wlast_err, m_err);
        if (!rd_busy) chk("rvalid_idle", rvalid, 1'b0);
        if (rd_lat == 1) begin
          chk("first_rvalid_early", rvalid, 1'b0);
          rd_lat = 2;
        end else if (rd_lat == 2) begin
          chk("first_rvalid_at_ar_plus2", rvalid, 1'b1);
          rd_lat = 0;
        end
        if (prev_stall) begin
          chk("stall_rvalid", rvalid, 1'b1);
          chk("stall_rdata", rdata, prev_rdata);
          chk("stall_rlast", rlast, prev_rlast);
        end
        if (prev_hs && exp_q.size() > 0) chk("no_bubble", rvalid, 1'b1);
        if (rvalid && rready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            if (e.known) chk("rdata", rdata, e.d);
            chk("rlast", rlast, e.last);
            lastpop = e.last;
          end
          rx_q.push_back(rdata);
        end
      end

      if (!aresetn) begin
        prev_rst = 1; wr_busy = 0; rd_busy = 0; m_err = 0; wr_left = 0;
        rd_lat = 0; prev_stall = 0; prev_hs = 0; exp_q.delete();
      end else if (!prev_rst) begin
        prev_stall = rvalid && !rready;
        prev_hs    = rvalid && rready;
        prev_rdata = rdata;
        prev_rlast = rlast;
        if (awvalid && awready) begin
          wr_busy = 1;
          wr_idx  = int'(awaddr[6 +: 10]);
          wr_left = int'(awlen) + 1;
        end
        if (wvalid && wready) begin
          for (int b = 0; b < NB; b++)
            if (wstrb[b]) m_mem[wr_idx][b*8 +: 8] = wdata[b*8 +: 8];
          if (&wstrb) m_known[wr_idx] = 1;
          if (wlast !== (wr_left == 1)) m_err = 1;
          wr_idx  = (wr_idx + 1) % DEPTH;
          wr_left = wr_left - 1;
        end
        if (bvalid && bready) wr_busy = 0;
        if (lastpop) rd_busy = 0;
        if (arvalid && arready) begin
          rd_busy = 1;
          rd_lat  = 1;
          idx     = int'(araddr[6 +: 10]);
          for (int i = 0; i <= int'(arlen); i++) begin
            e.d     = m_mem[(idx + i) % DEPTH];
            e.known = m_known[(idx + i) % DEPTH];
            e.last  = (i == int'(arlen));
            exp_q.push_back(e);
          end
        end
      end else begin
        prev_rst = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // mode: 0 zeros, 1 all ones, 2 random, 3 counting from 1
  task automatic fill(input int n, input int mode, input bit rand_strb);
    wd_q.delete();
    ws_q.delete();
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      d = '0;
      if (mode == 1) d = '1;
      else if (mode == 2) for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
      else if (mode == 3) d = DW'(i + 1);
      wd_q.push_back(d);
      ws_q.push_back(rand_strb ? {$urandom, $urandom} : {NB{1'b1}});
    end
  endtask

  // early < 0: wlast on the final beat; otherwise wlast only on beat 'early'
  task automatic write_burst(input logic [AW-1:0] addr, input int len, input int early, input bit gaps);
    int t;
    awaddr = addr; awlen = 8'(len); awvalid = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!awready && t < 300);
    chk("aw_handshake_wait", awready, 1'b1);
    @(posedge clk); #1;
    awvalid = 0;
    for (int b = 0; b <= len; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      wvalid = 1; wdata = wd_q[b]; wstrb = ws_q[b];
      wlast = (early >= 0) ? (b == early) : (b == len);
      t = 0;
      do begin @(negedge clk); t++; end while (!wready && t < 300);
      if (!wready) begin
        chk("w_handshake_wait", wready, 1'b1);
        wvalid = 0; wlast = 0;
        return;
      end
      @(posedge clk); #1;
      wvalid = 0; wlast = 0;
    end
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    bready = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bvalid && t < 300);
    chk("b_handshake_wait", bvalid, 1'b1);
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic read_burst(input logic [AW-1:0] addr, input int len, input int rpct);
    int t, target;
    target  = rx_q.size() + len + 1;
    araddr  = addr; arlen = 8'(len); arvalid = 1;
    rready  = ($urandom_range(0, 99) < rpct);
    t = 0;
    do begin @(negedge clk); t++; end while (!arready && t < 300);
    chk("ar_handshake_wait", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 0;
    t = 0;
    while (rx_q.size() < target && t < 5000) begin
      rready = ($urandom_range(0, 99) < rpct);
      @(posedge clk); #1;
      t++;
    end
    chk("r_beat_count", rx_q.size(), target);
    rready = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base, t;
    logic [DW-1:0] p_val, q_val;

    // reset held 5 cycles with both address valids high
    awvalid = 1; arvalid = 1;
    repeat (5) @(posedge clk);
    #1;
    awvalid = 0; arvalid = 0; aresetn = 1;
    @(negedge clk);
    chk("release_awready_still_low", {awready, arready}, 2'b00);
    @(negedge clk);
    chk("release_readies_high", {awready, arready}, 2'b11);
    @(posedge clk); #1;

    // 4-beat write of 1..4 at 0x40, then read back
    fill(4, 3, 0);
    write_burst(64'h40, 3, -1, 0);
    chk("model_word1", m_mem[1], DW'(1));
    chk("model_word4", m_mem[4], DW'(4));
    base = rx_q.size();
    read_burst(64'h40, 3, 100);
    for (int i = 0; i < 4; i++) chk("seq4_rdata", rx_q[base + i], DW'(i + 1));
    chk("seq4_no_wlast_err", wlast_err, 1'b0);

    // partial strobe: only byte 0 cleared
    fill(1, 1, 0);
    write_burst(64'h280, 0, -1, 0);
    fill(1, 0, 0);
    ws_q[0] = NB'(1);
    write_burst(64'h280, 0, -1, 1);
    base = rx_q.size();
    read_burst(64'h280, 0, 100);
    chk("partial_strobe", rx_q[base], {{(DW-8){1'b1}}, 8'h00});

    // 256-beat burst, random stalls, junk in ignored address bits
    fill(256, 2, 0);
    write_burst(64'h2000, 255, -1, 1);
    base = rx_q.size();
    read_burst(64'hABCD_0000_0000_203F, 255, 50);
    chk("burst256_first", rx_q[base], wd_q[0]);
    chk("burst256_last", rx_q[base + 255], wd_q[255]);

    // wrap at the top of the array with a misplaced wlast
    fill(2, 2, 0);
    write_burst(64'(1023 * NB), 1, 0, 0);
    chk("wrap_wlast_err", wlast_err, 1'b1);
    base = rx_q.size();
    read_burst(64'h0, 0, 100);
    chk("wrap_word0", rx_q[base], wd_q[1]);
    base = rx_q.size();
    read_burst(64'(1023 * NB), 1, 80);
    chk("wrap_read_top", rx_q[base], wd_q[0]);
    chk("wrap_read_wrapped", rx_q[base + 1], wd_q[1]);

    // concurrent 16-beat write (random strobes) and 16-beat read
    fill(16, 0, 0);
    write_burst(64'(600 * NB), 15, -1, 0);
    fill(16, 2, 1);
    fork
      write_burst(64'(600 * NB), 15, -1, 1);
      read_burst(64'h2000 + 64'(5 * NB), 15, 70);
    join
    read_burst(64'(600 * NB), 15, 60);

    // same-word read and write on the same edge returns the old value
    p_val = {NB{8'hA5}};
    q_val = {NB{8'h3C}};
    fill(1, 0, 0);
    wd_q[0] = p_val;
    write_burst(64'(700 * NB), 0, -1, 0);
    awaddr = 64'(700 * NB); awlen = 0; awvalid = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!awready && t < 300);
    chk("collide_aw_wait", awready, 1'b1);
    @(posedge clk); #1;
    awvalid = 0;
    araddr = 64'(700 * NB); arlen = 0; arvalid = 1; rready = 1;
    base = rx_q.size();
    @(negedge clk);
    chk("collide_arready", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 0;
    wvalid = 1; wdata = q_val; wstrb = '1; wlast = 1;
    @(negedge clk);
    chk("collide_wready", wready, 1'b1);
    @(posedge clk); #1;
    wvalid = 0; wlast = 0; bready = 1;
    t = 0;
    while ((rx_q.size() <= base || bvalid) && t < 300) begin @(posedge clk); #1; t++; end
    chk("collide_read_beat", rx_q.size(), base + 1);
    bready = 0; rready = 0;
    chk("collide_old_value", rx_q[base], p_val);
    base = rx_q.size();
    read_burst(64'(700 * NB), 0, 100);
    chk("collide_new_value", rx_q[base], q_val);

    // reset in the middle of a stalled read and an open write burst
    araddr = 64'h2000; arlen = 7; arvalid = 1; rready = 0;
    @(negedge clk);
    @(posedge clk); #1;
    arvalid = 0;
    awaddr = 64'(800 * NB); awlen = 3; awvalid = 1;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 0;
    repeat (3) begin @(posedge clk); #1; end
    chk("midburst_rvalid_before_reset", rvalid, 1'b1);
    aresetn = 0;
    repeat (2) begin @(posedge clk); #1; end
    aresetn = 1;
    repeat (2) @(negedge clk);
    chk("after_reset_err_cleared", wlast_err, 1'b0);
    chk("after_reset_no_rvalid", rvalid, 1'b0);
    @(posedge clk); #1;
    base = rx_q.size();
    read_burst(64'h40, 1, 100);
    chk("after_reset_read0", rx_q[base], DW'(1));
    chk("after_reset_read1", rx_q[base + 1], DW'(2));

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // hard stop if something stalls beyond every bounded wait
  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expired, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/interleave_example_axi_slave_mem.md
# interleave_example_axi_slave_mem

AXI4 memory-mapped responder (slave) backed by an on-chip RAM array, implementing the same reduced AXI4 signal set the kernel read/write masters drive: AW/W/B for writes, AR/R for reads, INCR bursts only. It sits at the far end of the kernel's `m_axi_*` port in unit and system benches, and as a scratch memory in standalone builds. It lets the full read → adder → write datapath run end-to-end without external DDR. Read and write channels run independent state machines against a dual-port array.

## Interface
- C_M_AXI_ADDR_WIDTH, 64, byte address width
- C_M_AXI_DATA_WIDTH, 512, data width in bits; LP_DW_BYTES = C_M_AXI_DATA_WIDTH/8
- C_MEM_DEPTH_WORDS, 1024, array depth in data words, power of two
- aclk  in  1  single clock for all logic
- aresetn  in  1  reset, synchronous, active-low
- s_axi_awvalid / s_axi_awready  in / out  1 / 1  write address handshake
- s_axi_awaddr  in  C_M_AXI_ADDR_WIDTH  burst start byte address
- s_axi_awlen  in  8  beats minus one
- s_axi_wvalid / s_axi_wready  in / out  1 / 1  write data handshake
- s_axi_wdata  in  C_M_AXI_DATA_WIDTH  write data
- s_axi_wstrb  in  C_M_AXI_DATA_WIDTH/8  byte enables
- s_axi_wlast  in  1  final write beat marker
- s_axi_bvalid / s_axi_bready  out / in  1 / 1  write response handshake (always OKAY, no bresp port)
- s_axi_arvalid / s_axi_arready  in / out  1 / 1  read address handshake
- s_axi_araddr  in  C_M_AXI_ADDR_WIDTH  burst start byte address
- s_axi_arlen  in  8  beats minus one
- s_axi_rvalid / s_axi_rready  out / in  1 / 1  read data handshake
- s_axi_rdata  out  C_M_AXI_DATA_WIDTH  read data
- s_axi_rlast  out  1  final read beat marker
- wlast_err  out  1  sticky: wlast disagreed with awlen beat count

## Operation
- Word index = addr[log2(LP_DW_BYTES) +: log2(C_MEM_DEPTH_WORDS)]; low byte-offset bits and high bits ignored; each beat increments index by 1, wrapping modulo depth.
- Write FSM: WR_IDLE (awready=1) → AW handshake latches index and beat count awlen+1 → WR_DATA (wready=1, one beat per W handshake, bytes written only where wstrb=1) → after beat awlen+1 → WR_RESP (bvalid=1) → B handshake → WR_IDLE.
- wlast_err set if wlast=1 on any beat but the last, or wlast=0 on the last; beat count, not wlast, ends the burst. Cleared only by reset.
- Read FSM: RD_IDLE (arready=1) → AR handshake latches index and count arlen+1 → RD_BURST: array read issued whenever output register empty or being consumed; rdata/rvalid/rlast registered and held stable while rvalid=1 and rready=0; rlast=1 only on beat arlen+1 → final R handshake → RD_IDLE.
- Read and write proceed concurrently. Same-word read and write in the same cycle: read returns old data; the write lands.
- Array contents not cleared by reset.

## Timing
- While aresetn=0 and the cycle after deassertion sampled: all outputs 0 (awready, wready, bvalid, arready, rvalid, rlast, rdata, wlast_err). awready/arready rise in the first cycle after the edge that samples aresetn=1.
- Reset mid-burst: both FSMs return to IDLE on the next edge; in-flight burst abandoned, no bvalid/rvalid emitted.
- AW handshake at edge k → wready=1 from cycle k+1; awready=0 from k+1 until B handshake.
- Last W handshake at edge k → bvalid=1 from cycle k+1; held until bready. B handshake at edge k → awready=1 from cycle k+1.
- AR handshake at edge k → first rvalid in cycle k+2; with rready held 1, one beat per cycle, no bubbles.
- rready low: rvalid, rdata, rlast frozen; no beat skipped or duplicated.
- Final R handshake at edge k → arready=1 from cycle k+1.
- Written data readable by any AR issued after the corresponding B handshake.

## Test plan
- Reset: hold aresetn=0 5 cycles with arvalid=awvalid=1 → all outputs 0, no handshake; awready=arready=1 one cycle after release.
- Write 4 beats (awaddr=0x40, awlen=3, wstrb all ones, data 1..4), then read same → rdata 1,2,3,4, rlast only on 4th, bvalid one cycle after last W.
- Partial strobes: word preloaded 0xFF..FF, write wstrb=0x...0001 data 0 → readback has only byte 0 cleared.
- Read 256-beat burst with rready toggled pseudo-randomly → 256 beats, in order, data stable while stalled, first rvalid exactly 2 cycles after AR.
- Wrap: depth 1024, awaddr=(1023·LP_DW_BYTES), awlen=1 → second beat lands at word 0; wlast early on beat 1 → wlast_err=1, still 2 beats accepted.
- Concurrent: 16-beat read and 16-beat write to disjoint regions overlapping in time → both complete, data correct; same-word same-cycle collision returns old value.
